// File: rtl/rot_pkg.sv
// rot_pkg: shared types for the rotate/shift lane.
//   rot_mode_e     operation encoding (ROL, ROR, SHL, SHR, ASR)
//   ROT_MODE_W     width of the mode field
//   is_legal_mode  true for encodings 000..100; 101..111 are illegal
package rot_pkg;

  localparam int ROT_MODE_W = 3;

  typedef enum logic [ROT_MODE_W-1:0] {
    ROT_ROL = 3'b000,
    ROT_ROR = 3'b001,
    ROT_SHL = 3'b010,
    ROT_SHR = 3'b011,
    ROT_ASR = 3'b100
  } rot_mode_e;

  function automatic logic is_legal_mode(input logic [ROT_MODE_W-1:0] m);
    return (m <= 3'b100);
  endfunction

endpackage

// File: rtl/rot_layer.sv
// rot_layer: one layer of the logarithmic shifter. When en is set the
// operand is moved by SHIFT positions according to mode; otherwise it
// passes through unchanged.
//   d, q       operand in / out (WIDTH bits)
//   en         this layer's amount bit (already gated by mode legality)
//   mode       operation
//   carry_in   last bit shifted out by earlier layers
//   carry_out  updated last-out bit; for shifts, the last enabled layer's
//              tap equals the overall last bit out, so a plain override
//              chain is enough. Rotates leave the chain alone; their
//              carry is taken from the final result.
module rot_layer
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  rot_mode_e        mode,
  input  logic             carry_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out
);

  always_comb begin
    q         = d;
    carry_out = carry_in;
    if (en) begin
      case (mode)
        ROT_ROL: q = {d[WIDTH-SHIFT-1:0], d[WIDTH-1:WIDTH-SHIFT]};
        ROT_ROR: q = {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
        ROT_SHL: begin
          q         = {d[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
          carry_out = d[WIDTH-SHIFT];
        end
        ROT_SHR: begin
          q         = {{SHIFT{1'b0}}, d[WIDTH-1:SHIFT]};
          carry_out = d[SHIFT-1];
        end
        ROT_ASR: begin
          q         = {{SHIFT{d[WIDTH-1]}}, d[WIDTH-1:SHIFT]};
          carry_out = d[SHIFT-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rot_shift_unit.sv
// rot_shift_unit: elastic two-stage rotate/shift lane (ROL, ROR, SHL, SHR,
// ASR) with valid/ready on both sides, 2-cycle latency, 1 beat/cycle.
//   clk, rst                    clock; asynchronous active-high reset
//   in_valid/in_ready           operand handshake
//   in_a, in_amt, in_mode       operand, amount (0..WIDTH-1), operation
//   out_valid/out_ready         result handshake
//   out_y                       result
//   out_carry, out_zero, out_err  last bit out, result==0, illegal mode
// Build option: define ROT_FLAGS_EN to compute and register the three
// flags; without it they are tied 0 and the flag logic is dropped.
// Stage 1 applies the low amount-bit layers, stage 2 the high ones.
module rot_shift_unit
  import rot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [ROT_MODE_W-1:0]    in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_err
);

  localparam int AW = $clog2(WIDTH);
  localparam int LO = AW / 2;

  logic s1_adv, s2_adv;
  logic in_legal;

  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]      s1_data_q, s1_data_d;
  logic [ROT_MODE_W-1:0] s1_mode_q, s1_mode_d;
  logic [AW-LO-1:0]      s1_amt_q, s1_amt_d;
  logic                  s1_legal_q, s1_legal_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      y_q, y_d;

  logic [WIDTH-1:0] s1_chain [0:LO];
  logic [WIDTH-1:0] s2_chain [LO:AW];
  logic [LO:0]      c1;
  logic [AW:LO]     c2;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_legal = is_legal_mode(in_mode);

  assign s1_chain[0] = in_a;
  assign c1[0]       = 1'b0;
  assign s2_chain[LO] = s1_data_q;

  // Illegal modes disable every layer so the operand passes through intact.
  for (genvar k = 0; k < LO; k++) begin : g_s1
    rot_layer #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_layer (
      .d         (s1_chain[k]),
      .en        (in_legal && in_amt[k]),
      .mode      (rot_mode_e'(in_mode)),
      .carry_in  (c1[k]),
      .q         (s1_chain[k+1]),
      .carry_out (c1[k+1])
    );
  end

  for (genvar k = LO; k < AW; k++) begin : g_s2
    rot_layer #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_layer (
      .d         (s2_chain[k]),
      .en        (s1_legal_q && s1_amt_q[k-LO]),
      .mode      (rot_mode_e'(s1_mode_q)),
      .carry_in  (c2[k]),
      .q         (s2_chain[k+1]),
      .carry_out (c2[k+1])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mode_d   = s1_mode_q;
    s1_amt_d    = s1_amt_q;
    s1_legal_d  = s1_legal_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d  = s1_chain[LO];
        s1_mode_d  = in_mode;
        s1_amt_d   = in_amt[AW-1:LO];
        s1_legal_d = in_legal;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) y_d = s2_chain[AW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= '0;
      s1_amt_q    <= '0;
      s1_legal_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      s1_amt_q    <= s1_amt_d;
      s1_legal_q  <= s1_legal_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = y_q;

`ifdef ROT_FLAGS_EN
  logic s1_carry_q, s1_carry_d;
  logic s1_amt_nz_q, s1_amt_nz_d;
  logic carry_q, carry_d;
  logic zero_q, zero_d;
  logic err_q, err_d;

  assign c2[LO] = s1_carry_q;

  always_comb begin
    s1_carry_d  = s1_carry_q;
    s1_amt_nz_d = s1_amt_nz_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    if (s1_adv && in_valid) begin
      s1_carry_d  = c1[LO];
      s1_amt_nz_d = |in_amt;
    end
    if (s2_adv && s1_valid_q) begin
      // Rotates report the bit that wrapped last, i.e. the result LSB/MSB.
      case (s1_mode_q)
        ROT_ROL: carry_d = s1_amt_nz_q && s2_chain[AW][0];
        ROT_ROR: carry_d = s1_amt_nz_q && s2_chain[AW][WIDTH-1];
        default: carry_d = c2[AW];
      endcase
      zero_d = (s2_chain[AW] == '0);
      err_d  = !s1_legal_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_carry_q  <= 1'b0;
      s1_amt_nz_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_carry_q  <= s1_carry_d;
      s1_amt_nz_q <= s1_amt_nz_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign out_carry = carry_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;
`else
  logic unused_carry;

  assign c2[LO]       = 1'b0;
  assign unused_carry = ^{c1[LO], c2[AW]};
  assign out_carry    = 1'b0;
  assign out_zero     = 1'b0;
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_rot_shift_unit.sv
// Directed bench for rot_shift_unit (WIDTH=8). Flag expectations collapse
// to 0 when ROT_FLAGS_EN is not defined.
module tb_rot_shift_unit;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
`ifdef ROT_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  localparam logic [2:0] M_ROL = 3'b000;
  localparam logic [2:0] M_ROR = 3'b001;
  localparam logic [2:0] M_SHL = 3'b010;
  localparam logic [2:0] M_SHR = 3'b011;
  localparam logic [2:0] M_ASR = 3'b100;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  int n_pass  = 0;
  int n_total = 0;

  rot_shift_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] y,
                            input bit c, input bit z, input bit e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_y"},     32'(out_y),     32'(y));
    check({tag, "_carry"}, 32'(out_carry), 32'(c & FL));
    check({tag, "_zero"},  32'(out_zero),  32'(z & FL));
    check({tag, "_err"},   32'(out_err),   32'(e & FL));
  endtask

  task automatic drive(input logic [7:0] a, input logic [2:0] amt, input logic [2:0] mode);
    in_valid = 1'b1;
    in_a     = a;
    in_amt   = amt;
    in_mode  = mode;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_amt   = '0;
    in_mode  = '0;
  endtask

  // Offer one beat at the current falling edge; result is checked two edges later.
  task automatic single(input string tag, input logic [7:0] a, input logic [2:0] amt,
                        input logic [2:0] mode, input logic [7:0] y,
                        input bit c, input bit z, input bit e);
    drive(a, amt, mode);
    @(negedge clk);
    idle();
    check({tag, "_nolat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    expect_out(tag, y, c, z, e);
  endtask

  logic [7:0] b_a   [4] = '{8'h01, 8'h81, 8'hF0, 8'h12};
  logic [2:0] b_amt [4] = '{3'd1, 3'd1, 3'd5, 3'd7};
  logic [2:0] b_mode[4] = '{M_ROR, M_SHL, M_SHL, M_ROR};
  logic [7:0] b_y   [4] = '{8'h80, 8'h02, 8'h00, 8'h24};
  bit         b_c   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit         b_z   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_y",     32'(out_y),     32'd0);
    check("rst_carry", 32'(out_carry), 32'd0);
    check("rst_zero",  32'(out_zero),  32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Single beats across all operations, including amount 0 and max amount.
    single("rol81",  8'h81, 3'd1, M_ROL, 8'h03, 1'b1, 1'b0, 1'b0);
    single("asr80",  8'h80, 3'd3, M_ASR, 8'hF0, 1'b0, 1'b0, 1'b0);
    single("shr0f",  8'h0F, 3'd4, M_SHR, 8'h00, 1'b1, 1'b1, 1'b0);
    single("rolamt0",8'hA5, 3'd0, M_ROL, 8'hA5, 1'b0, 1'b0, 1'b0);
    single("asrc3",  8'hC3, 3'd1, M_ASR, 8'hE1, 1'b1, 1'b0, 1'b0);
    single("asr7f",  8'h7F, 3'd7, M_ASR, 8'h00, 1'b1, 1'b1, 1'b0);

    // Back-to-back stream: four consecutive results, no bubbles.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(b_a[i], b_amt[i], b_mode[i]);
      else idle();
      check($sformatf("b2b_ready%0d", i), 32'(in_ready), 32'd1);
      if (i >= 2) expect_out($sformatf("b2b%0d", i - 2), b_y[i-2], b_c[i-2], b_z[i-2], 1'b0);
      @(negedge clk);
    end
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: two beats fill the pipe, the third waits for release.
    out_ready = 1'b0;
    drive(8'h01, 3'd7, M_SHL);
    check("bp_ready0", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(8'hFF, 3'd2, M_SHR);
    check("bp_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(8'h0F, 3'd4, M_ROL);
    check("bp_ready2", 32'(in_ready), 32'd0);
    expect_out("bp_a_hold0", 8'h80, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready3", 32'(in_ready), 32'd0);
    expect_out("bp_a_hold1", 8'h80, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_rel", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle();
    expect_out("bp_b", 8'h3F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("bp_c", 8'hF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_drain", 32'(out_valid), 32'd0);

    // Illegal modes pass the operand through and flag the error.
    single("ill7", 8'h5A, 3'd3, 3'b111, 8'h5A, 1'b0, 1'b0, 1'b1);
    single("ill5", 8'h00, 3'd2, 3'b101, 8'h00, 1'b0, 1'b1, 1'b1);

    // Reset with two beats in flight flushes both.
    drive(8'h01, 3'd1, M_ROL);
    @(negedge clk);
    drive(8'h10, 3'd1, M_SHR);
    @(negedge clk);
    idle();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y",     32'(out_y),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_stale%0d", i), 32'(out_valid), 32'd0);
    end
    single("post_rst", 8'h03, 3'd2, M_SHL, 8'h0C, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
